// File: rtl/uart_tx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx_param                                                   |
// | Purpose  : Parametrised UART transmitter. Serialises one DATA_BITS word    |
// |            per frame, LSB first: start bit, data bits, optional parity     |
// |            bit (even/odd), then one or two stop bits. Valid/ready input    |
// |            handshake with gap-free back-to-back frames.                    |
// | Params   : DATA_BITS    payload bits per frame (5..9)                      |
// |            CLKS_PER_BIT clk cycles per bit period (>= 2)                   |
// | Ports    : clk          system clock, rising edge                          |
// |            rst_n        synchronous active-low reset                       |
// |            en           gates acceptance of new frames only                |
// |            tx_valid     producer has a word on tx_data                     |
// |            tx_data      word to send                                       |
// |            tx_ready     word accepted at this edge when tx_valid=1         |
// |            parity_mode  00 none, 01 even, 10 odd, 11 none                  |
// |            two_stop     0 = one stop bit, 1 = two stop bits                |
// |            tx_out       registered serial line, idle high                  |
// |            busy         frame in progress                                  |
// |            done         pulse in last cycle of final stop bit              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  c_bit_last  = BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_start  = 3'd1;
    localparam logic [2:0] c_st_data   = 3'd2;
    localparam logic [2:0] c_st_parity = 3'd3;
    localparam logic [2:0] c_st_stop   = 3'd4;

    logic [2:0]           r_state;
    logic [BAUD_W-1:0]    r_baud;
    logic [BIT_W-1:0]     r_bit;      // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en;
    logic                 r_par_bit;
    logic                 r_two_stop;
    logic                 r_tx;

    logic [2:0]           w_state_nxt;
    logic [BAUD_W-1:0]    w_baud_nxt;
    logic [BIT_W-1:0]     w_bit_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_par_en_nxt;
    logic                 w_par_bit_nxt;
    logic                 w_two_stop_nxt;
    logic                 w_tx_nxt;

    logic w_baud_last;
    logic w_stop_last;
    logic w_accept;

    assign w_baud_last = (r_baud == c_baud_last);
    // Final cycle of the final stop bit: the only busy cycle that may accept.
    assign w_stop_last = (r_state == c_st_stop) && w_baud_last &&
                         (r_bit == BIT_W'(r_two_stop));

    assign tx_ready = rst_n & en & ((r_state == c_st_idle) | w_stop_last);
    assign w_accept = tx_valid & tx_ready;
    assign busy     = (r_state != c_st_idle);
    assign done     = w_stop_last;
    assign tx_out   = r_tx;

    always_comb begin
        w_state_nxt    = r_state;
        w_baud_nxt     = r_baud;
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_two_stop_nxt = r_two_stop;
        w_tx_nxt       = r_tx;

        if (r_state != c_st_idle) begin
            w_baud_nxt = w_baud_last ? '0 : r_baud + BAUD_W'(1);
        end

        case (r_state)
            c_st_start: begin
                if (w_baud_last) begin
                    w_state_nxt = c_st_data;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            c_st_data: begin
                if (w_baud_last) begin
                    if (r_bit == c_bit_last) begin
                        w_bit_nxt = '0;
                        if (r_par_en) begin
                            w_state_nxt = c_st_parity;
                            w_tx_nxt    = r_par_bit;
                        end else begin
                            w_state_nxt = c_st_stop;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        // Shift so the next bit to send moves into position 0.
                        w_bit_nxt   = r_bit + BIT_W'(1);
                        w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
                        w_tx_nxt    = r_shift[1];
                    end
                end
            end
            c_st_parity: begin
                if (w_baud_last) begin
                    w_state_nxt = c_st_stop;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = 1'b1;
                end
            end
            c_st_stop: begin
                if (w_baud_last && !w_stop_last) begin
                    w_bit_nxt = r_bit + BIT_W'(1);
                end else if (w_stop_last && !w_accept) begin
                    w_state_nxt = c_st_idle;
                    w_bit_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Acceptance (from IDLE or the final stop cycle) latches the whole
        // frame configuration, so later input changes cannot disturb it.
        if (w_accept) begin
            w_state_nxt    = c_st_start;
            w_baud_nxt     = '0;
            w_bit_nxt      = '0;
            w_shift_nxt    = tx_data;
            w_par_en_nxt   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            w_par_bit_nxt  = (^tx_data) ^ (parity_mode == 2'b10);
            w_two_stop_nxt = two_stop;
            w_tx_nxt       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_baud     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_two_stop <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud     <= w_baud_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_two_stop <= w_two_stop_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx_param                                                |
// | Purpose  : Self-checking bench for uart_tx_param. A frame-level line model |
// |            (queue of expected line values) is compared every cycle with   |
// |            the main instance (8 bits, 4 clk/bit); directed frames pin the  |
// |            model with hand-written waveforms; a second instance (5 bits,   |
// |            2 clk/bit) covers the small-parameter corner.                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_tx_param;

    localparam int CPB  = 4;
    localparam int CPB2 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, tx_valid, two_stop;
    logic [7:0] tx_data;
    logic [1:0] parity_mode;
    logic       tx_ready, tx_out, busy, done;

    logic       valid2, ts2;
    logic [4:0] data2;
    logic [1:0] pm2;
    logic       ready2, tx2, busy2, done2;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .parity_mode(parity_mode), .two_stop(two_stop),
        .tx_out(tx_out), .busy(busy), .done(done));

    uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB2)) dut_small (
        .clk(clk), .rst_n(rst_n), .en(en), .tx_valid(valid2), .tx_data(data2),
        .tx_ready(ready2), .parity_mode(pm2), .two_stop(ts2),
        .tx_out(tx2), .busy(busy2), .done(done2));

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // ---------------- line model ----------------
    // q holds the line value for every remaining cycle of the frame in flight.
    bit q[$];
    bit chk_on = 1'b0;

    function automatic void push_frame(logic [7:0] d, logic [1:0] pm, logic ts);
        bit b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 8; i++) b.push_back(d[i]);
        if (pm == 2'b01) b.push_back(^d);
        if (pm == 2'b10) b.push_back(~^d);
        b.push_back(1'b1);
        if (ts) b.push_back(1'b1);
        foreach (b[k]) for (int r = 0; r < CPB; r++) q.push_back(b[k]);
    endfunction

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            q.delete();
        end else begin
            acc = tx_valid && en && (q.size() <= 1);
            if (q.size() > 0) void'(q.pop_front());
            if (acc) push_frame(tx_data, parity_mode, two_stop);
        end
        chk_on = 1'b1;
    end

    always @(negedge clk) begin
        int n;
        if (chk_on) begin
            n = q.size();
            chk("model_tx_out", int'(tx_out), (n > 0) ? int'(q[0]) : 1);
            chk("model_busy", int'(busy), int'(n > 0));
            chk("model_done", int'(done), int'(n == 1));
            chk("model_ready", int'(tx_ready), int'(rst_n && en && n <= 1));
        end
    end

    // ---------------- directed helpers ----------------
    logic cap [0:199];
    logic capb[0:199];
    logic capd[0:199];
    logic capr[0:199];

    // Waits (bounded) until the main instance accepts; returns just after that edge.
    task automatic wait_accept(string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_ready) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk({nm, "_accept_timeout"}, 0, 1);
    endtask

    task automatic capture(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[i] = tx_out; capb[i] = busy; capd[i] = done; capr[i] = tx_ready;
        end
    endtask

    // vec[k] is the expected value of bit period k; off is the capture offset.
    task automatic chk_frame(string nm, logic [15:0] vec, int nbits, int off);
        int bad = 0;
        for (int i = 0; i < nbits * CPB; i++)
            if (cap[off + i] !== vec[i / CPB]) bad++;
        chk({nm, "_wave_errors"}, bad, 0);
        chk({nm, "_done_last_cycle"}, int'(capd[off + nbits * CPB - 1]), 1);
    endtask

    function automatic int count_ones(int from, int to, int which);
        int c = 0;
        for (int i = from; i < to; i++) begin
            if (which == 0 && capb[i] === 1'b1) c++;
            if (which == 1 && capd[i] === 1'b1) c++;
            if (which == 2 && capr[i] === 1'b1) c++;
            if (which == 3 && cap[i]  === 1'b0) c++;
        end
        return c;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
        parity_mode = 2'b00; two_stop = 1'b0;
        valid2 = 1'b0; data2 = 5'd0; pm2 = 2'b00; ts2 = 1'b0;

        // Reset state: ready held low by rst_n even with en & valid high.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_out", int'(tx_out), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_ready", int'(tx_ready), 0);
        @(posedge clk); #1;
        rst_n = 1'b1; tx_valid = 1'b0;
        @(negedge clk);
        chk("idle_ready", int'(tx_ready), 1);
        @(posedge clk); #1;

        // 1: 0xA5, no parity, one stop -> 10 bit periods, done at cycle 39.
        tx_data = 8'hA5; tx_valid = 1'b1;
        wait_accept("a5");
        tx_valid = 1'b0;
        capture(48);
        chk_frame("a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 0);
        chk("a5_busy_cycles", count_ones(0, 48, 0), 40);
        chk("a5_done_count", count_ones(0, 48, 1), 1);

        // 2: 0x07 even parity -> parity 1; inputs changed after acceptance.
        tx_data = 8'h07; parity_mode = 2'b01; tx_valid = 1'b1;
        wait_accept("p_even");
        tx_valid = 1'b0; tx_data = 8'hFF; parity_mode = 2'b00;
        capture(48);
        chk_frame("p_even", {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0);
        chk("p_even_busy_cycles", count_ones(0, 48, 0), 44);

        tx_data = 8'h07; parity_mode = 2'b10; tx_valid = 1'b1;
        wait_accept("p_odd");
        tx_valid = 1'b0;
        capture(48);
        chk_frame("p_odd", {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0);
        chk("p_odd_busy_cycles", count_ones(0, 48, 0), 44);

        // 3: back-to-back 0x55 then 0xAA with two stop bits.
        parity_mode = 2'b00; two_stop = 1'b1; tx_data = 8'h55; tx_valid = 1'b1;
        wait_accept("b2b");
        tx_data = 8'hAA;
        for (int i = 0; i < 92; i++) begin
            @(negedge clk);
            cap[i] = tx_out; capb[i] = busy; capd[i] = done; capr[i] = tx_ready;
            if (i == 43) begin
                @(posedge clk); #1;
                tx_valid = 1'b0;
            end
        end
        chk_frame("b2b_first", {5'b0, 2'b11, 8'h55, 1'b0}, 11, 0);
        chk_frame("b2b_second", {5'b0, 2'b11, 8'hAA, 1'b0}, 11, 44);
        chk("b2b_ready_final_stop", int'(capr[43]), 1);
        chk("b2b_ready_early", count_ones(0, 43, 2), 0);
        chk("b2b_busy_cycles", count_ones(0, 92, 0), 88);
        two_stop = 1'b0;

        // 4: enable gating.
        en = 1'b0; tx_data = 8'h3F; tx_valid = 1'b1;
        capture(20);
        chk("en0_ready", count_ones(0, 20, 2), 0);
        chk("en0_line_low", count_ones(0, 20, 3), 0);
        chk("en0_busy", count_ones(0, 20, 0), 0);
        @(posedge clk); #1;
        en = 1'b1;
        wait_accept("en_frame");
        tx_data = 8'h81;
        repeat (10) @(posedge clk);
        #1 en = 1'b0;
        capture(40);
        chk("en_drop_done", count_ones(0, 40, 1), 1);
        chk("en_drop_ready", count_ones(0, 40, 2), 0);
        chk("en_drop_idle_busy", count_ones(30, 40, 0), 0);
        @(posedge clk); #1;
        en = 1'b1;
        wait_accept("en_resume");
        tx_valid = 1'b0;
        capture(44);
        chk_frame("en_resume", {6'b0, 1'b1, 8'h81, 1'b0}, 10, 0);

        // 5: reset in the first cycle of data bit 3.
        tx_data = 8'hC3; tx_valid = 1'b1;
        wait_accept("rst_mid");
        tx_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_tx_out", int'(tx_out), 1);
        chk("rst_mid_busy", int'(busy), 0);
        capture(50);
        chk("rst_mid_no_done", count_ones(0, 50, 1), 0);
        tx_data = 8'h3C; tx_valid = 1'b1;
        wait_accept("after_rst");
        tx_valid = 1'b0;
        capture(44);
        chk_frame("after_rst", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 0);

        // 6: small instance, odd parity on 5'b10011 -> bits 1,1,0,0,1 parity 0.
        begin
            logic [7:0] v6;
            int bad, busyc, done_at, ok;
            v6 = {1'b1, 1'b0, 5'b10011, 1'b0};
            data2 = 5'b10011; pm2 = 2'b10; ts2 = 1'b0; valid2 = 1'b1;
            ok = 0;
            for (int i = 0; i < 50 && ok == 0; i++) begin
                @(negedge clk);
                if (ready2) ok = 1;
            end
            chk("small_accept", ok, 1);
            @(posedge clk); #1;
            valid2 = 1'b0; pm2 = 2'b00; data2 = 5'b00000;
            bad = 0; busyc = 0; done_at = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (i < 16 && tx2 !== v6[i / CPB2]) bad++;
                if (i >= 16 && tx2 !== 1'b1) bad++;
                if (busy2 === 1'b1) busyc++;
                if (done2 === 1'b1 && done_at < 0) done_at = i;
            end
            chk("small_wave_errors", bad, 0);
            chk("small_busy_cycles", busyc, 16);
            chk("small_done_at", done_at, 15);
        end

        // Random traffic against the line model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            en          = ($urandom_range(0, 15) != 0);
            tx_valid    = ($urandom_range(0, 2) != 0);
            tx_data     = 8'($urandom);
            parity_mode = 2'($urandom);
            two_stop    = 1'($urandom);
            rst_n       = ($urandom_range(0, 400) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; tx_valid = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        chk("final_idle_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
